// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and FSM state type for the round-robin arbiter
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational first-set-bit search over 8 requests starting at a rotating base
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   base,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_any
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest set bit above base wins.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = base + IDX_W'(i);
      if (req[cand]) begin
        pick_idx = cand;
        pick_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with registered valid/ready grant index
module rr_arbiter8 #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = 3,
  parameter int LOCK_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               lock,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  input  logic               gnt_ready
);

  generate
    if (NUM_REQ != 8 || IDX_W != 3) begin : g_bad_size
      $error("rr_arbiter8 only supports NUM_REQ=8, IDX_W=3");
    end
  endgenerate

  arb_pkg::arb_state_e state_q, state_d;
  logic                gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0]    gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0]    prio_q, prio_d;
  logic [IDX_W-1:0]    hs_ptr;
  logic [IDX_W-1:0]    base;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;
  logic                lock_eff;
  logic                hs;

  assign lock_eff = (LOCK_EN != 0) ? lock : 1'b0;
  assign hs       = gnt_valid_q && gnt_ready;
  // Pointer after an accepted grant: stay on the winner when locked, otherwise step past it.
  assign hs_ptr   = lock_eff ? gnt_idx_q : gnt_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
  // While a grant is pending the only search that matters is the one on the handshake edge.
  assign base     = (state_q == arb_pkg::ARB_GRANT) ? hs_ptr : prio_q;

  rr_pick8 u_pick (
    .req      (req),
    .base     (base),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  // Next-state: issue, hold until accepted, then re-arbitrate or fall idle.
  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    prio_d      = prio_q;
    unique case (state_q)
      arb_pkg::ARB_IDLE: begin
        if (pick_any) begin
          gnt_idx_d   = pick_idx;
          gnt_valid_d = 1'b1;
          state_d     = arb_pkg::ARB_GRANT;
        end
      end
      arb_pkg::ARB_GRANT: begin
        if (hs) begin
          prio_d = hs_ptr;
          if (pick_any) begin
            gnt_idx_d = pick_idx;
          end else begin
            gnt_valid_d = 1'b0;
            state_d     = arb_pkg::ARB_IDLE;
          end
        end
      end
      default: begin
        state_d     = arb_pkg::ARB_IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers; reset drops any pending grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= arb_pkg::ARB_IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      prio_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      prio_q      <= prio_d;
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed and random checks of rr_arbiter8 against a reference model
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       lock = 1'b0;
  logic       gnt_ready = 1'b0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_ptr = 0;
  int m_idx = 0;
  bit m_valid = 0;

  rr_arbiter8 #(.NUM_REQ(8), .IDX_W(3), .LOCK_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .lock      (lock),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .gnt_ready (gnt_ready)
  );

  always #5 clk = ~clk;

  function automatic int first_set(input logic [7:0] r, input int b);
    for (int off = 0; off < 8; off++) begin
      int k;
      k = (b + off) % 8;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0;
    m_idx = 0;
    m_valid = 0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic l, input logic rd);
    int p;
    if (!m_valid) begin
      p = first_set(r, m_ptr);
      if (p >= 0) begin
        m_idx = p;
        m_valid = 1;
      end
    end else if (rd) begin
      m_ptr = l ? m_idx : (m_idx + 1) % 8;
      p = first_set(r, m_ptr);
      if (p >= 0) m_idx = p;
      else m_valid = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs are applied 1ns after a rising edge; outputs are checked 1ns after the next one
  task automatic cycle(input logic [7:0] r, input logic l, input logic rd, input string tag);
    req = r;
    lock = l;
    gnt_ready = rd;
    @(posedge clk);
    model_step(r, l, rd);
    #1;
    chk({tag, "_valid"}, {31'd0, gnt_valid}, {31'd0, m_valid});
    chk({tag, "_idx"}, {29'd0, gnt_idx}, m_idx);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 8'h00;
    lock = 1'b0;
    gnt_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    // reset values
    @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, gnt_valid}, 32'd0);
    chk("reset_idx", {29'd0, gnt_idx}, 32'd0);
    rst_n = 1'b1;

    // rotation: 0..7,0,1
    for (int i = 0; i < 10; i++) begin
      cycle(8'hFF, 1'b0, 1'b1, "rot");
      chk("rot_seq", {29'd0, gnt_idx}, i % 8);
    end

    // reset mid-grant takes effect without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, gnt_valid}, 32'd0);
    chk("async_rst_idx", {29'd0, gnt_idx}, 32'd0);
    model_reset();
    req = 8'h00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(8'h00, 1'b0, 1'b0, "post_rst_idle");
      chk("post_rst_noval", {31'd0, gnt_valid}, 32'd0);
    end

    // wrap and skip
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(8'h81, 1'b0, 1'b1, "wrap");
      chk("wrap_seq", {29'd0, gnt_idx}, (i % 2) ? 32'd7 : 32'd0);
    end

    // hold under backpressure, request withdrawn while pending
    do_reset();
    cycle(8'h10, 1'b0, 1'b0, "hold1");
    for (int i = 0; i < 3; i++) begin
      cycle(8'h00, 1'b0, 1'b0, "hold");
      chk("hold_idx4", {29'd0, gnt_idx}, 32'd4);
      chk("hold_valid", {31'd0, gnt_valid}, 32'd1);
    end
    cycle(8'h00, 1'b0, 1'b1, "hold_accept");
    chk("hold_drop", {31'd0, gnt_valid}, 32'd0);

    // lock keeps the winner on top
    do_reset();
    cycle(8'h0C, 1'b0, 1'b0, "lock_first");
    chk("lock_first_idx", {29'd0, gnt_idx}, 32'd2);
    cycle(8'h0C, 1'b1, 1'b1, "lock_hs");
    chk("lock_again2", {29'd0, gnt_idx}, 32'd2);
    cycle(8'h0C, 1'b0, 1'b1, "unlock_hs");
    chk("unlock_next3", {29'd0, gnt_idx}, 32'd3);
    cycle(8'h00, 1'b0, 1'b1, "lock_drain");

    // ready without valid leaves the pointer (now 4) alone
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, 1'b1, "rdy_novalid");
    cycle(8'h21, 1'b0, 1'b0, "rdy_after");
    chk("rdy_ptr_kept", {29'd0, gnt_idx}, 32'd5);

    do_reset();
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, 1'b1, "rdy_novalid0");
    cycle(8'h01, 1'b0, 1'b1, "rdy_req1");
    chk("rdy_grant0", {29'd0, gnt_idx}, 32'd0);
    chk("rdy_grant0_v", {31'd0, gnt_valid}, 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      else if ($urandom_range(0, 2) == 0) r = r & 8'($urandom);
      cycle(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that sits directly upstream of `decoder3x8`. It picks one active requester and presents its 3-bit index with a valid/ready handshake. The downstream consumer takes `gnt_idx` and feeds it to `decoder3x8` to produce the one-hot grant/select lines. The grant is registered and held stable until accepted, and fairness rotates after every accepted grant.

## Interface
- `NUM_REQ`, 8: number of requesters. Only 8 is supported; an elaboration assertion fires otherwise.
- `IDX_W`, 3: index width, `$clog2(NUM_REQ)`.
- `LOCK_EN`, 1: 1 honours `lock`; 0 ties `lock` off internally.

- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset. Assertion takes effect immediately; deassertion is synchronised externally.
- `req`, input, 8: request vector. Bit i high means requester i wants a grant.
- `lock`, input, 1: sampled only on an accepted handshake. When high, the same requester keeps top priority for the next search.
- `gnt_valid`, output, 1: a grant is pending on `gnt_idx`.
- `gnt_idx`, output, 3: index of the granted requester, for `decoder3x8`.
- `gnt_ready`, input, 1: downstream accepts the grant this cycle.

## Operation
- **State machine**, two states `ARB_IDLE` and `ARB_GRANT`:
  - `ARB_IDLE`: if `|req`, load `gnt_idx` with the pick and set `gnt_valid` (go to `ARB_GRANT`). Otherwise stay.
  - `ARB_GRANT`: hold `gnt_idx` and `gnt_valid`. On `gnt_valid && gnt_ready`:
    - Update `prio_ptr`.
    - If `|req` in the same cycle, load the new pick and stay in `ARB_GRANT` (back-to-back grants).
    - Otherwise clear `gnt_valid` and go to `ARB_IDLE`.
- **Pick rule:** the first set bit of `req`, scanning upward from the search base with wrap 7→0.
  - In `ARB_IDLE` the base is `prio_ptr`.
  - On a handshake the base is the updated `prio_ptr`.
- **Pointer update on handshake:** `prio_ptr <= (lock && LOCK_EN) ? gnt_idx : gnt_idx + 1`. The increment is mod 8 by natural 3-bit wrap.
- **No retraction:** once `gnt_valid` is high, `gnt_idx` does not change until the handshake, even if `req[gnt_idx]` falls.
- `gnt_ready` while `gnt_valid` is low is ignored and has no state effect.
- **Simultaneous events:** the `req` value sampled on the handshake edge is what feeds the next pick. The requester just granted is still eligible, at lowest priority unless locked.

## Timing
- Reset values:
  - `gnt_valid` = 0
  - `gnt_idx` = 3'd0
  - `prio_ptr` = 3'd0
  - state = `ARB_IDLE`
- Latency: `req` first high at edge N (in `ARB_IDLE`) gives `gnt_valid` = 1 after edge N. One cycle, registered output.
- Throughput: one grant per cycle while `gnt_ready` is held high and requests persist.
- `gnt_valid` and `gnt_idx` come straight from flops, with no combinational path from `req` or `gnt_ready`.
- Reset mid-grant clears `gnt_valid` asynchronously. The pending grant is lost and the pointer returns to 0.
- `req` all zero: no grant is issued and `gnt_idx` holds its last value.

## Structure
- Package `arb_pkg`:
  - `localparam NUM_REQ = 8`
  - `localparam IDX_W = 3`
  - `typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_e`
- Sub-module `rr_pick8`: purely combinational rotate-and-priority-encode.
  - Inputs: `req[7:0]`, `base[2:0]`.
  - Outputs: `pick_idx[2:0]`, `pick_any`.
- The top level holds the FSM, `prio_ptr` and the output registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-grant → `gnt_valid`=0 immediately and `gnt_idx`=0. After release with `req`=8'h00 for 5 cycles → `gnt_valid` stays 0.
- **Rotation:** `req`=8'hFF, `gnt_ready`=1 constantly, `lock`=0 → `gnt_idx` sequence 0,1,2,…,7,0,1 on consecutive cycles.
- **Wrap and skip:** `req`=8'h81 with `prio_ptr`=0 → grants 0, 7, 0, 7 alternating.
- **Hold under backpressure:** `req`=8'h10, `gnt_ready`=0 for 4 cycles with `req` dropped to 0 after cycle 1 → `gnt_idx`=4 and `gnt_valid`=1 throughout. Handshake at cycle 5 → `gnt_valid`=0 next cycle.
- **Lock:** `req`=8'h0C, `lock`=1 on the first handshake (grant 2) → next grant 2. Then `lock`=0 → next grant 3.
- **Ready without valid:** `gnt_ready`=1 with `req`=0 for 3 cycles → `prio_ptr` unchanged. Subsequent `req`=8'h01 → grant 0 after 1 cycle.
